// File: rtl/cache_controller.sv
// ---------------------------------------------------------------------------
// cache_controller
//   Miss-handling sequencer for the 2-way data cache. Each CPU load/store is
//   walked through: tag lookup -> (dirty victim write-back) -> line refill ->
//   one-cycle fill -> replayed lookup. The pipeline is stalled while any of
//   these steps is outstanding. Main memory is reached over a req/ready
//   handshake guarded by a bounded-wait timeout that raises a sticky Error.
//
// Optional build macro:
//   CACHE_PERF_CNT_EN - adds saturating HitCount / MissCount / WbCount outputs.
//
// Ports:
//   CLK         in   clock, rising edge
//   RST         in   asynchronous active-low reset
//   MemRead     in   CPU load request (held stable while Stall=1)
//   MemWrite    in   CPU store request (held stable while Stall=1)
//   A           in   CPU byte address
//   hit         in   tag-match result for A (valid in LOOKUP)
//   dirty       in   victim line dirty (valid in LOOKUP)
//   VictimA     in   word address of the victim line
//   MemReady    in   memory completes the current transfer this cycle
//   Stall       out  freeze PC/pipeline
//   CacheLookup out  cache compares tags this cycle
//   CacheFill   out  cache writes refill data (single cycle)
//   MemReq      out  memory transfer active
//   MemWE       out  1 = write-back, 0 = refill read (valid with MemReq)
//   MemAddr     out  memory word address, bits [1:0] always 0
//   Error       out  sticky memory-timeout flag
//   HitCount/MissCount/WbCount  out  perf counters (CACHE_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module cache_controller #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic                  hit,
  input  logic                  dirty,
  input  logic [DATA_WIDTH-1:0] VictimA,
  input  logic                  MemReady,
  output logic                  Stall,
  output logic                  CacheLookup,
  output logic                  CacheFill,
  output logic                  MemReq,
  output logic                  MemWE,
  output logic [DATA_WIDTH-1:0] MemAddr,
  output logic                  Error
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  HitCount,
  output logic [CNT_WIDTH-1:0]  MissCount,
  output logic [CNT_WIDTH-1:0]  WbCount
`endif
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WRITEBACK = 3'd2,
    S_REFILL    = 3'd3,
    S_FILL      = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(MEM_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  tmo_q,   tmo_d;
  logic                  error_q, error_d;

  // A store wins over a load when both are raised; the sequence is identical
  // either way, so only the OR matters here.
  logic req;
  assign req = MemRead | MemWrite;

  // Byte-offset bits never reach memory; this keeps them visibly consumed.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{A[1:0], VictimA[1:0]};

  logic mem_phase;
  assign mem_phase = (state_q == S_WRITEBACK) || (state_q == S_REFILL);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    error_d = error_q;

    unique case (state_q)
      S_IDLE: begin
        if (req) state_d = S_LOOKUP;
      end

      S_LOOKUP: begin
        if (!req || hit) begin
          // Retire on hit; a dropped request leaves without memory traffic.
          state_d = S_IDLE;
        end else if (dirty) begin
          state_d = S_WRITEBACK;
          tmo_d   = '0;
        end else begin
          state_d = S_REFILL;
          tmo_d   = '0;
        end
      end

      S_WRITEBACK, S_REFILL: begin
        if (MemReady) begin
          // Completion beats a timeout landing on the same cycle.
          if (state_q == S_WRITEBACK) begin
            state_d = S_REFILL;
            tmo_d   = '0;
          end else begin
            state_d = S_FILL;
          end
        end else if (tmo_q >= TMO_LAST) begin
          // Abort: MemReq drops on this same edge since IDLE drives no request.
          error_d = 1'b1;
          state_d = S_IDLE;
        end else if (tmo_q != CNT_MAX) begin
          tmo_d = tmo_q + CNT_WIDTH'(1);
        end
      end

      S_FILL: begin
        // Replay the lookup; the freshly filled line is guaranteed to hit.
        state_d = S_LOOKUP;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode (Moore on state, except Stall which also looks at req/hit)
  // -------------------------------------------------------------------------
  always_comb begin
    Stall       = 1'b0;
    CacheLookup = 1'b0;
    CacheFill   = 1'b0;
    MemReq      = 1'b0;
    MemWE       = 1'b0;
    MemAddr     = '0;

    unique case (state_q)
      S_LOOKUP:    CacheLookup = 1'b1;
      S_WRITEBACK: begin
        MemReq  = 1'b1;
        MemWE   = 1'b1;
        MemAddr = {VictimA[DATA_WIDTH-1:2], 2'b00};
      end
      S_REFILL: begin
        MemReq  = 1'b1;
        MemAddr = {A[DATA_WIDTH-1:2], 2'b00};
      end
      S_FILL:      CacheFill = 1'b1;
      default: ;
    endcase

    // Stall is gated by RST so every output is 0 while reset is held, even
    // though the CPU may still be presenting a request.
    Stall = RST & ((req && !((state_q == S_LOOKUP) && hit)) ||
                   mem_phase || (state_q == S_FILL));
  end

  assign Error = error_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      error_q <= error_d;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  // -------------------------------------------------------------------------
  // Performance counters
  // -------------------------------------------------------------------------
  logic                 replay_q, replay_d;
  logic [CNT_WIDTH-1:0] hit_cnt_q,  hit_cnt_d;
  logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
  logic [CNT_WIDTH-1:0] wb_cnt_q,   wb_cnt_d;

  always_comb begin
    // FILL always leads into exactly one LOOKUP cycle, so remembering "last
    // cycle was FILL" marks the replay lookup that must not count as a hit.
    replay_d   = (state_q == S_FILL);
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;

    if ((state_q == S_LOOKUP) && req && hit && !replay_q && (hit_cnt_q != CNT_MAX))
      hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
    if ((state_q == S_LOOKUP) && req && !hit && (miss_cnt_q != CNT_MAX))
      miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
    if ((state_q == S_WRITEBACK) && MemReady && (wb_cnt_q != CNT_MAX))
      wb_cnt_d = wb_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      replay_q   <= replay_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign HitCount  = hit_cnt_q;
  assign MissCount = miss_cnt_q;
  assign WbCount   = wb_cnt_q;
`endif

endmodule
